// File: rtl/hysteresis_edge_track.sv
// Final Canny stage: single-pass 8-neighbour hysteresis over a 3x3 window.
// Two line buffers supply the rows above the incoming pixel; a 3x3 register
// window is centred one row and one column behind the input position.
module hysteresis_edge_track #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int STRONG_VAL = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    output logic       frame_done
);
    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW = $clog2(IMG_HEIGHT + 2);
    localparam logic [7:0] STRONG = 8'(STRONG_VAL);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_live;
    logic [CW-1:0]   r_col, r_ocol;     // input position / centre position
    logic [RW-1:0]   r_row, r_orow;
    logic [7:0]      r_lb0 [IMG_WIDTH]; // row above input
    logic [7:0]      r_lb1 [IMG_WIDTH]; // two rows above input
    logic [7:0]      r_win [3][3];      // [col][row], col 0 = left, row 0 = top
    logic [7:0]      w_win [3][3];
    logic [7:0]      r_dout;
    logic            r_vld, r_fd;
    logic            w_acc, w_shift, w_emit, w_last_in, w_last_out, w_hit;
    logic [7:0]      w_pix, w_res;
    logic [2:0]      w_cok, w_rok;

    assign data_in_ready  = r_live && (r_state == RUN);
    assign data_out       = r_dout;
    assign data_out_valid = r_vld;
    assign frame_done     = r_fd;

    assign w_acc      = data_in_valid && data_in_ready;
    // Drain keeps the window moving with zero padding below the last row.
    assign w_shift    = w_acc || (r_state == DRAIN);
    assign w_pix      = (r_state == DRAIN) ? 8'd0 : data_in;
    // Window is full once pixel IMG_WIDTH+1 arrives; drain rows are beyond that.
    assign w_emit     = w_shift && ((r_row > RW'(1)) || (r_row == RW'(1) && r_col != '0));
    assign w_last_in  = (r_row == RW'(IMG_HEIGHT - 1)) && (r_col == CW'(IMG_WIDTH - 1));
    assign w_last_out = (r_orow == RW'(IMG_HEIGHT - 1)) && (r_ocol == CW'(IMG_WIDTH - 1));

    // Neighbour masks: off-image rows/cols (and column wrap) read as zero.
    assign w_cok = {r_ocol != CW'(IMG_WIDTH - 1), 1'b1, r_ocol != '0};
    assign w_rok = {r_orow != RW'(IMG_HEIGHT - 1), 1'b1, r_orow != '0};

    // Window as it will look after this shift; the output is classified from it.
    always_comb begin
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 3; r++)
                w_win[c][r] = r_win[c+1][r];
        w_win[2][0] = r_lb1[r_col];
        w_win[2][1] = r_lb0[r_col];
        w_win[2][2] = w_pix;
    end

    // Strong-neighbour detection and centre classification.
    always_comb begin
        w_hit = 1'b0;
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++)
                if (!(c == 1 && r == 1) && w_cok[c] && w_rok[r] && w_win[c][r] == STRONG)
                    w_hit = 1'b1;
        w_res = 8'd0;
        if (w_win[1][1] == STRONG || (w_win[1][1] != 8'd0 && w_hit))
            w_res = 8'hFF;
    end

    // Next-state logic: RUN until the last pixel is taken, DRAIN until the last output.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (w_acc && w_last_in) w_state_nxt = DRAIN;
            DRAIN:   if (w_last_out)         w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    // State, position counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_live  <= 1'b0;
            r_col   <= '0;
            r_row   <= '0;
            r_ocol  <= '0;
            r_orow  <= '0;
            r_dout  <= 8'd0;
            r_vld   <= 1'b0;
            r_fd    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
            r_vld   <= w_emit;
            r_fd    <= w_emit && w_last_out;
            if (w_emit)
                r_dout <= w_res;
            if (r_state == DRAIN && w_last_out) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_shift) begin
                if (r_col == CW'(IMG_WIDTH - 1)) begin
                    r_col <= '0;
                    r_row <= r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
            if (w_emit) begin
                if (r_ocol == CW'(IMG_WIDTH - 1)) begin
                    r_ocol <= '0;
                    r_orow <= w_last_out ? '0 : r_orow + RW'(1);
                end else begin
                    r_ocol <= r_ocol + CW'(1);
                end
            end
        end
    end

    // Line buffers and window; stale contents are masked by the counters.
    always_ff @(posedge clk) begin
        if (w_shift) begin
            r_lb1[r_col] <= r_lb0[r_col];
            r_lb0[r_col] <= w_pix;
            for (int c = 0; c < 3; c++)
                for (int r = 0; r < 3; r++)
                    r_win[c][r] <= w_win[c][r];
        end
    end
endmodule

// File: tb/tb_hysteresis_edge_track.sv
// Directed bench for hysteresis_edge_track (4x3 image) with an output scoreboard.
module tb_hysteresis_edge_track;
    localparam int W = 4, H = 3, N = W * H;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic [7:0] data_out;
    logic       data_out_valid, frame_done;

    hysteresis_edge_track #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .STRONG_VAL(255)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready), .data_out(data_out),
        .data_out_valid(data_out_valid), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] d; logic fd; } exp_t;

    int   errors = 0, checks = 0, fd_cnt = 0;
    int   img [H][W];
    exp_t sbq [$];
    logic acc_ok = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference hysteresis for one pixel of the current image.
    function automatic logic [7:0] gold(input int r, input int c);
        bit s = 0;
        if (img[r][c] == 255) return 8'hFF;
        if (img[r][c] == 0) return 8'h00;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < H &&
                    c + dc >= 0 && c + dc < W && img[r+dr][c+dc] == 255)
                    s = 1;
        return s ? 8'hFF : 8'h00;
    endfunction

    task automatic push(input int k);
        exp_t e;
        e.d  = gold(k / W, k % W);
        e.fd = (k == N - 1);
        sbq.push_back(e);
    endtask

    task automatic clr_img();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 0;
    endtask

    // An output is legal only after an accept or while input is blocked (drain).
    always @(posedge clk) acc_ok <= (data_in_valid && data_in_ready) || !data_in_ready;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && data_out_valid) begin
            chk("out_timing", acc_ok, 1);
            if (sbq.size() == 0) chk("sb_underflow", sbq.size(), 1);
            else begin
                e = sbq.pop_front();
                chk("data_out", data_out, e.d);
                chk("frame_done", frame_done, e.fd);
            end
            if (frame_done) fd_cnt++;
        end
    end

    // Drive one pixel from the negedge; it is accepted at the following posedge.
    task automatic send_pix(input int k, input int gap);
        int t;
        while (gap > 0 && $urandom_range(1, 100) <= gap) begin
            data_in_valid = 1'b0;
            @(negedge clk);
        end
        data_in       = 8'(img[k / W][k % W]);
        data_in_valid = 1'b1;
        for (t = 0; t < 50 && !data_in_ready; t++) @(negedge clk);
        if (!data_in_ready) chk("ready_timeout", data_in_ready, 1);
        if (k >= W + 1) push(k - W - 1);
        @(negedge clk);
    endtask

    task automatic send_frame(input int gap, input bit nxt_valid, input int nxt_val);
        int lowc = 0;
        for (int k = 0; k < N; k++) send_pix(k, gap);
        for (int k = N - W - 1; k < N; k++) push(k);
        data_in_valid = nxt_valid;
        data_in       = 8'(nxt_val);
        for (int t = 0; t < 20 && !data_in_ready; t++) begin
            lowc++;
            @(negedge clk);
        end
        chk("drain_ready_low", lowc, W + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        // Reset state
        #12;
        chk("rst_valid", data_out_valid, 0);
        chk("rst_dout", data_out, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_ready", data_in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("ready_pre_edge", data_in_ready, 0);
        @(negedge clk);
        chk("ready_post_edge", data_in_ready, 1);

        // All-zero frame
        clr_img();
        send_frame(0, 0, 0);

        // Single strong with weak neighbours and a non-adjacent weak
        clr_img();
        img[1][1] = 255; img[0][0] = 100; img[2][2] = 100; img[0][3] = 100;
        send_frame(0, 0, 0);

        // Column wrap must not form a neighbour
        clr_img();
        img[0][3] = 255; img[1][0] = 150; img[1][2] = 150;
        send_frame(0, 0, 0);

        // Scenario 2 again with ~50% input gaps
        clr_img();
        img[1][1] = 255; img[0][0] = 100; img[2][2] = 100; img[0][3] = 100;
        send_frame(50, 0, 0);

        // Back-to-back frames; valid held high through the drain
        clr_img();
        for (int c = 0; c < W; c++) img[2][c] = 255;
        img[1][0] = 77;
        send_frame(0, 1, 100);
        clr_img();
        for (int c = 0; c < W; c++) img[0][c] = 100;
        send_frame(0, 0, 0);

        // Mid-frame asynchronous reset after 7 accepts
        clr_img();
        img[0][1] = 255; img[1][3] = 90;
        for (int k = 0; k < 7; k++) send_pix(k, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", data_out_valid, 0);
        chk("mid_rst_dout", data_out, 0);
        chk("mid_rst_ready", data_in_ready, 0);
        chk("mid_rst_fd", frame_done, 0);
        data_in_valid = 1'b0;
        sbq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(0, 0, 0);

        repeat (5) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        chk("frame_count", fd_cnt, 7);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
